// File: rtl/debug_dump_tx_pkg.sv
// -----------------------------------------------------------------------------
// debug_dump_tx_pkg
// Shared types and constants for the architectural-state dump path.
//   state_t      : dump sequencer states
//   *_DEF        : default widths/counts used as module parameter defaults
//   REG_BASE     : word index of the first GPR in the dump order
//   words_total(): number of words in one dump (PC + GPRs + memory words)
//   mem_base()   : word index of the first memory word
// -----------------------------------------------------------------------------
package debug_dump_tx_pkg;

    localparam int unsigned NB_DATA_DEF     = 32;
    localparam int unsigned N_BITS_DEF      = 8;
    localparam int unsigned NB_PC_DEF       = 7;
    localparam int unsigned N_REGISTER_DEF  = 32;
    localparam int unsigned NB_REG_DEF      = 5;
    localparam int unsigned N_MEM_WORDS_DEF = 32;
    localparam int unsigned NB_MEM_ADDR_DEF = 5;

    localparam int unsigned REG_BASE = 1;

    function automatic int unsigned words_total(input int unsigned n_reg,
                                                input int unsigned n_mem);
        return 1 + n_reg + n_mem;
    endfunction

    function automatic int unsigned mem_base(input int unsigned n_reg);
        return REG_BASE + n_reg;
    endfunction

    localparam int unsigned WORDS_TOTAL    = words_total(N_REGISTER_DEF, N_MEM_WORDS_DEF);
    localparam int unsigned BYTES_PER_WORD = NB_DATA_DEF / N_BITS_DEF;
    localparam int unsigned MEM_BASE       = mem_base(N_REGISTER_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/debug_dump_tx_if.sv
// -----------------------------------------------------------------------------
// debug_dump_tx_if
// Bundles the dump block's debug read ports and the tx_uart handshake.
//   reg_addr_o/reg_data_i : GPR debug port, data combinational from address
//   mem_addr_o/mem_data_i : data-memory debug port, data one cycle after addr
//   tx_start_o/tx_data_o  : byte launch towards tx_uart
//   tx_done_i             : tx_uart per-byte done tick
// master = dump block, slave = register file / memory / transmitter side.
// -----------------------------------------------------------------------------
interface debug_dump_tx_if
    import debug_dump_tx_pkg::*;
#(
    parameter int unsigned NB_DATA     = NB_DATA_DEF,
    parameter int unsigned N_BITS      = N_BITS_DEF,
    parameter int unsigned NB_REG      = NB_REG_DEF,
    parameter int unsigned NB_MEM_ADDR = NB_MEM_ADDR_DEF
);
    logic [NB_REG-1:0]      reg_addr_o;
    logic [NB_DATA-1:0]     reg_data_i;
    logic [NB_MEM_ADDR-1:0] mem_addr_o;
    logic [NB_DATA-1:0]     mem_data_i;
    logic                   tx_start_o;
    logic [N_BITS-1:0]      tx_data_o;
    logic                   tx_done_i;

    modport master (
        output reg_addr_o, mem_addr_o, tx_start_o, tx_data_o,
        input  reg_data_i, mem_data_i, tx_done_i
    );

    modport slave (
        input  reg_addr_o, mem_addr_o, tx_start_o, tx_data_o,
        output reg_data_i, mem_data_i, tx_done_i
    );
endinterface

// File: rtl/debug_dump_tx_word_byte_serializer.sv
// -----------------------------------------------------------------------------
// word_byte_serializer
// Holds one word and presents it a byte at a time, LSB first.
//   clock, reset  : system clock, async active-high reset
//   i_load        : capture i_word, restart at byte 0
//   i_word        : word to serialize
//   i_advance     : current byte acknowledged; step to the next one
//   o_byte        : current byte (low bits of the shift register)
//   o_last_byte   : current byte is the final one of the word
// -----------------------------------------------------------------------------
module word_byte_serializer
    import debug_dump_tx_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF,
    parameter int unsigned N_BITS  = N_BITS_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_advance,
    output logic [N_BITS-1:0]  o_byte,
    output logic               o_last_byte
);
    localparam int unsigned BPW    = NB_DATA / N_BITS;
    localparam int unsigned NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;

    logic [NB_DATA-1:0] r_shift;
    logic [NB_CNT-1:0]  r_byte_cnt;
    logic               w_last;

    assign w_last      = (r_byte_cnt == NB_CNT'(BPW - 1));
    assign o_byte      = r_shift[N_BITS-1:0];
    assign o_last_byte = w_last;

    // The final byte is not shifted out so tx_data stays put after its ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_load) begin
            r_shift    <= i_word;
            r_byte_cnt <= '0;
        end else if (i_advance) begin
            if (w_last) begin
                r_byte_cnt <= '0;
            end else begin
                r_shift    <= r_shift >> N_BITS;
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/debug_dump_tx.sv
// -----------------------------------------------------------------------------
// debug_dump_tx
// Dumps architectural state over tx_uart after the program finishes:
// PC (zero-extended), GPR[0..N_REGISTER-1], MEM[0..N_MEM_WORDS-1],
// each word LSB first, one byte per tx_done tick.
//   clock, reset : system clock, async active-high reset
//   start_i      : dump request pulse, honoured only when idle
//   pc_i         : final PC, captured when the PC word is fetched
//   busy_o       : dump in progress
//   dump_done_o  : one-cycle pulse after the last byte is acknowledged
//   dbg          : debug read ports and tx_uart handshake (master side)
// -----------------------------------------------------------------------------
module debug_dump_tx
    import debug_dump_tx_pkg::*;
#(
    parameter int unsigned NB_DATA     = NB_DATA_DEF,
    parameter int unsigned N_BITS      = N_BITS_DEF,
    parameter int unsigned NB_PC       = NB_PC_DEF,
    parameter int unsigned N_REGISTER  = N_REGISTER_DEF,
    parameter int unsigned NB_REG      = NB_REG_DEF,
    parameter int unsigned N_MEM_WORDS = N_MEM_WORDS_DEF,
    parameter int unsigned NB_MEM_ADDR = NB_MEM_ADDR_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic [NB_PC-1:0] pc_i,
    output logic             busy_o,
    output logic             dump_done_o,
    debug_dump_tx_if.master  dbg
);
    localparam int unsigned WORDS  = words_total(N_REGISTER, N_MEM_WORDS);
    localparam int unsigned MEM_B  = mem_base(N_REGISTER);
    localparam int unsigned NB_IDX = $clog2(WORDS);
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(WORDS - 1);

    state_t                 r_state;
    logic [NB_IDX-1:0]      r_word_idx;
    logic [NB_REG-1:0]      r_reg_addr;
    logic [NB_MEM_ADDR-1:0] r_mem_addr;
    logic                   r_tx_start;
    logic                   r_busy;
    logic                   r_dump_done;

    logic [NB_IDX-1:0]      w_next_idx;
    logic                   w_cur_is_mem;
    logic                   w_next_is_reg;
    logic                   w_load;
    logic                   w_advance;
    logic [NB_DATA-1:0]     w_word;
    logic [N_BITS-1:0]      w_byte;
    logic                   w_last_byte;

    assign w_next_idx    = r_word_idx + 1'b1;
    assign w_cur_is_mem  = (32'(r_word_idx) >= MEM_B);
    assign w_next_is_reg = (32'(w_next_idx) < MEM_B);
    assign w_load        = ((r_state == ST_FETCH) && !w_cur_is_mem) || (r_state == ST_LOAD);
    assign w_advance     = (r_state == ST_WAIT) && dbg.tx_done_i;

    always_comb begin
        w_word = dbg.reg_data_i;
        if (r_state == ST_LOAD) begin
            w_word = dbg.mem_data_i;
        end else if (r_word_idx == '0) begin
            w_word = NB_DATA'(pc_i);
        end
    end

    word_byte_serializer #(
        .NB_DATA (NB_DATA),
        .N_BITS  (N_BITS)
    ) u_serializer (
        .clock       (clock),
        .reset       (reset),
        .i_load      (w_load),
        .i_word      (w_word),
        .i_advance   (w_advance),
        .o_byte      (w_byte),
        .o_last_byte (w_last_byte)
    );

    // Debug addresses are registered on the way into FETCH (from NEXT), so
    // the combinational GPR read is already valid in FETCH and the synchronous
    // memory read lands in LOAD. The address port not used by a word holds.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_word_idx  <= '0;
            r_reg_addr  <= '0;
            r_mem_addr  <= '0;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_dump_done <= 1'b0;
        end else begin
            r_tx_start  <= 1'b0;
            r_dump_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_word_idx <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_cur_is_mem) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_tx_start <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_LOAD: begin
                    r_tx_start <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dbg.tx_done_i) begin
                        if (w_last_byte) begin
                            r_state <= ST_NEXT;
                        end else begin
                            r_tx_start <= 1'b1;
                            r_state    <= ST_SEND;
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_word_idx == LAST_IDX) begin
                        r_dump_done <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_word_idx <= w_next_idx;
                        if (w_next_is_reg) begin
                            r_reg_addr <= NB_REG'(32'(w_next_idx) - REG_BASE);
                        end else begin
                            r_mem_addr <= NB_MEM_ADDR'(32'(w_next_idx) - MEM_B);
                        end
                        r_state <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg.reg_addr_o = r_reg_addr;
    assign dbg.mem_addr_o = r_mem_addr;
    assign dbg.tx_start_o = r_tx_start;
    assign dbg.tx_data_o  = w_byte;
    assign busy_o         = r_busy;
    assign dump_done_o    = r_dump_done;
endmodule

// File: tb/tb_debug_dump_tx.sv
// -----------------------------------------------------------------------------
// tb_debug_dump_tx
// Drives debug_dump_tx with a GPR file, a one-cycle-latency data memory and a
// tx_uart stand-in that answers each tx_start with a done tick after a set
// delay. Expected bytes come from a hand table and from the bench's own
// PC/GPR/MEM contents.
// -----------------------------------------------------------------------------
module tb_debug_dump_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_i;
    logic [6:0] pc_i;
    logic       busy_o;
    logic       dump_done_o;

    debug_dump_tx_if #(
        .NB_DATA     (32),
        .N_BITS      (8),
        .NB_REG      (5),
        .NB_MEM_ADDR (5)
    ) dbg ();

    debug_dump_tx #(
        .NB_DATA     (32),
        .N_BITS      (8),
        .NB_PC       (7),
        .N_REGISTER  (32),
        .NB_REG      (5),
        .N_MEM_WORDS (32),
        .NB_MEM_ADDR (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_i     (start_i),
        .pc_i        (pc_i),
        .busy_o      (busy_o),
        .dump_done_o (dump_done_o),
        .dbg         (dbg)
    );

    always #5 clock = ~clock;

    // register file (combinational) and data memory (1-cycle read)
    logic [31:0] gpr [32];
    logic [31:0] mem [32];
    assign dbg.reg_data_i = gpr[dbg.reg_addr_o];
    always @(posedge clock) dbg.mem_data_i <= mem[dbg.mem_addr_o];

    int n_cmp  = 0;
    int n_fail = 0;

    // monitor + transmitter stand-in
    int         pulse_cnt  = 0;
    int         done_cnt   = 0;
    int         resp_cnt   = 0;
    int         done_delay = 3;
    bit         spur       = 1'b0;
    logic [7:0] cap       [300];
    logic [4:0] cap_raddr [300];
    logic [4:0] cap_maddr [300];

    always @(negedge clock) begin
        logic real_done;
        if (dump_done_o === 1'b1) done_cnt++;
        if (dbg.tx_start_o === 1'b1) begin
            if (pulse_cnt < 300) begin
                cap[pulse_cnt]       = dbg.tx_data_o;
                cap_raddr[pulse_cnt] = dbg.reg_addr_o;
                cap_maddr[pulse_cnt] = dbg.mem_addr_o;
            end
            pulse_cnt++;
        end
        real_done = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) real_done = 1'b1;
        end
        if (dbg.tx_start_o === 1'b1) resp_cnt = done_delay;
        dbg.tx_done_i = real_done | (spur & ((dbg.tx_start_o === 1'b1) | (busy_o !== 1'b1)));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        int w;
        int b;
        logic [31:0] word;
        w = i / 4;
        b = i % 4;
        if (w == 0)       word = {25'b0, pc_i};
        else if (w <= 32) word = gpr[w-1];
        else              word = mem[w-33];
        return word[8*b +: 8];
    endfunction

    function automatic int model_errors(input int n);
        int e = 0;
        for (int i = 0; i < n; i++) if (cap[i] !== exp_byte(i)) e++;
        return e;
    endfunction

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clock); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            @(negedge clock); #1;
            if (dump_done_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pulses(input int n, input int max, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            @(negedge clock); #1;
            if (pulse_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int         idx;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [18];

    initial begin
        bit ok;
        int saved;

        tbl = '{'{0, 8'h2A}, '{1, 8'h00}, '{2, 8'h00}, '{3, 8'h00},
                '{4, 8'h00}, '{5, 8'h00}, '{6, 8'h00}, '{7, 8'h00},
                '{8, 8'hEF}, '{9, 8'hBE}, '{10, 8'hAD}, '{11, 8'hDE},
                '{132, 8'h67}, '{133, 8'h45}, '{134, 8'h23}, '{135, 8'h01},
                '{256, 8'h0D}, '{259, 8'hCA}};

        for (int k = 0; k < 32; k++) begin
            gpr[k] = {8'(k), 8'h5A, 8'(k), 8'hC3};
            mem[k] = 32'hA500_0000 | 32'(k);
        end
        gpr[0]  = 32'h0;
        gpr[1]  = 32'hDEADBEEF;
        mem[0]  = 32'h01234567;
        mem[31] = 32'hCAFEF00D;

        // reset with start_i held high: the request must be ignored
        pc_i    = 7'h2A;
        start_i = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("rst_tx_start", 32'(dbg.tx_start_o), 32'd0);
        check("rst_tx_data",  32'(dbg.tx_data_o),  32'd0);
        check("rst_busy",     32'(busy_o),         32'd0);
        check("rst_done",     32'(dump_done_o),    32'd0);
        check("rst_reg_addr", 32'(dbg.reg_addr_o), 32'd0);
        check("rst_mem_addr", 32'(dbg.mem_addr_o), 32'd0);
        start_i = 1'b0;
        reset   = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("start_in_reset_ignored", 32'(busy_o), 32'd0);

        // full dump, done returned 3 cycles after each start
        pulse_cnt = 0; done_cnt = 0; resp_cnt = 0;
        pulse_start();
        check("busy_after_start", 32'(busy_o), 32'd1);
        wait_done(5000, ok);
        check("dump_done_seen", 32'(ok), 32'd1);
        check("pulses_at_done", 32'(pulse_cnt), 32'd260);
        @(negedge clock); #1;
        check("busy_falls", 32'(busy_o), 32'd0);
        check("done_width", 32'(dump_done_o), 32'd0);
        repeat (5) @(negedge clock); #1;
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("total_pulses", 32'(pulse_cnt), 32'd260);

        for (int v = 0; v < 18; v++) begin
            check($sformatf("byte%0d", tbl[v].idx), 32'(cap[tbl[v].idx]), 32'(tbl[v].exp));
        end
        check("model_bytes_run1", 32'(model_errors(260)), 32'd0);
        check("reg_addr_gpr1",  32'(cap_raddr[8]),   32'd1);
        check("mem_addr_mem0",  32'(cap_maddr[132]), 32'd0);
        check("mem_addr_mem31", 32'(cap_maddr[259]), 32'd31);

        // spurious done in IDLE/SEND, start re-pulsed mid-dump
        spur = 1'b1; done_delay = 2;
        repeat (4) @(negedge clock); #1;
        check("spur_idle_ignored", 32'(busy_o), 32'd0);
        pulse_cnt = 0; done_cnt = 0; resp_cnt = 0;
        pulse_start();
        for (int r = 0; r < 4; r++) begin
            repeat (97) @(negedge clock);
            #1;
            pulse_start();
        end
        wait_done(5000, ok);
        check("spur_done_seen", 32'(ok), 32'd1);
        check("spur_pulses", 32'(pulse_cnt), 32'd260);
        check("model_bytes_spur", 32'(model_errors(260)), 32'd0);
        repeat (3) @(negedge clock); #1;
        check("spur_done_pulses", 32'(done_cnt), 32'd1);
        spur = 1'b0;

        // reset while waiting on byte 50, then restart from the PC
        done_delay = 3;
        pulse_cnt = 0; done_cnt = 0; resp_cnt = 0;
        repeat (2) @(negedge clock); #1;
        pulse_start();
        wait_pulses(50, 2000, ok);
        check("reach_byte50", 32'(ok), 32'd1);
        @(negedge clock); #1;
        check("pre_abort_busy", 32'(busy_o), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_tx_start", 32'(dbg.tx_start_o), 32'd0);
        check("abort_tx_data",  32'(dbg.tx_data_o),  32'd0);
        check("abort_busy",     32'(busy_o),         32'd0);
        check("abort_done",     32'(dump_done_o),    32'd0);
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b0;
        saved = pulse_cnt;
        repeat (6) @(negedge clock); #1;
        check("no_tx_after_abort", 32'(pulse_cnt), 32'(saved));
        pulse_cnt = 0;
        pulse_start();
        wait_pulses(2, 100, ok);
        check("restart_seen", 32'(ok), 32'd1);
        check("restart_byte0", 32'(cap[0]), 32'h2A);
        check("restart_byte1", 32'(cap[1]), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
